// File: rtl/mem_arbiter_if.sv
// Signal bundle between the two requesters, the arbiter and the single-port memory.
// slave = arbiter view, master = requester/memory environment view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter (IDLE/OWN0/OWN1) in front of a single-port memory with 1-cycle read latency.
// Macro ARB_ROUND_ROBIN_EN: round-robin ties and MAX_HOLD preemption of either owner; undefined = port 0 priority.

module mem_arbiter_checker (
  input logic clk,
  input logic reset,
  input logic gnt0,
  input logic gnt1,
  input logic we0,
  input logic we1,
  input logic mem_en,
  input logic rvalid0,
  input logic rvalid1,
  input logic last
);
  a_gnt_exclusive: assert property (@(posedge clk) disable iff (reset) !(gnt0 && gnt1));
  a_mem_en_match:  assert property (@(posedge clk) disable iff (reset) mem_en == (gnt0 || gnt1));
  a_rvalid0_read:  assert property (@(posedge clk) disable iff (reset) rvalid0 |-> $past(gnt0 && !we0));
  a_rvalid1_read:  assert property (@(posedge clk) disable iff (reset) rvalid1 |-> $past(gnt1 && !we1));
  a_last_owner:    assert property (@(posedge clk) disable iff (reset) (gnt0 |-> !last) and (gnt1 |-> last));
endmodule

module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [8:0] MAX_HOLD_C = 9'(MAX_HOLD);

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic RR_EN        = 1'b1;
  localparam logic PREEMPT_OWN0 = 1'b1;
`else
  localparam logic RR_EN        = 1'b0;
  localparam logic PREEMPT_OWN0 = 1'b0;
`endif
  localparam logic PREEMPT_OWN1 = 1'b1;

  state_t            state_r;
  state_t            state_next_s;
  logic [7:0]        hold_cnt_r;
  logic [7:0]        hold_cnt_next_s;
  logic              last_r;
  logic              last_next_s;
  logic              rvalid0_r;
  logic              rvalid1_r;
  logic              gnt0_s;
  logic              gnt1_s;
  logic              access_s;
  logic [8:0]        hold_sum_s;
  logic              hold_full_s;
  logic [7:0]        hold_sat_s;
  logic              tie_to1_s;
  logic              mem_en_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_s;

  // Grant follows the owner's request combinationally; the other port is held off.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    case (state_r)
      OWN0:    gnt0_s = bus.req0;
      OWN1:    gnt1_s = bus.req1;
      default: begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
      end
    endcase
  end

  // Memory command mux: only a granted port reaches the memory.
  always_comb begin
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = {ADDR_W{1'b0}};
    mem_wdata_s = {DATA_W{1'b0}};
    if (gnt0_s) begin
      mem_en_s    = 1'b1;
      mem_we_s    = bus.we0;
      mem_addr_s  = bus.addr0;
      mem_wdata_s = bus.wdata0;
    end else if (gnt1_s) begin
      mem_en_s    = 1'b1;
      mem_we_s    = bus.we1;
      mem_addr_s  = bus.addr1;
      mem_wdata_s = bus.wdata1;
    end else begin
      mem_en_s = 1'b0;
    end
  end

  // Hold count including the access happening this cycle; 9 bits so MAX_HOLD=255 cannot wrap.
  assign access_s    = gnt0_s | gnt1_s;
  assign hold_sum_s  = {1'b0, hold_cnt_r} + {8'd0, access_s};
  assign hold_full_s = (hold_sum_s >= MAX_HOLD_C);
  assign hold_sat_s  = hold_full_s ? MAX_HOLD_C[7:0] : hold_sum_s[7:0];
  assign tie_to1_s   = RR_EN ? ~last_r : 1'b0;

  // Next-state arbitration.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          state_next_s = tie_to1_s ? OWN1 : OWN0;
        end else if (bus.req0) begin
          state_next_s = OWN0;
        end else if (bus.req1) begin
          state_next_s = OWN1;
        end else begin
          state_next_s = IDLE;
        end
      end
      OWN0: begin
        if (bus.req1 && (!bus.req0 || (PREEMPT_OWN0 && hold_full_s))) begin
          state_next_s = OWN1;
        end else if (!bus.req0) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = OWN0;
        end
      end
      OWN1: begin
        if (bus.req0 && (!bus.req1 || (PREEMPT_OWN1 && hold_full_s))) begin
          state_next_s = OWN0;
        end else if (!bus.req1) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = OWN1;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Hold counter restarts on every ownership change; last winner tracks each entry into OWNn.
  always_comb begin
    hold_cnt_next_s = hold_cnt_r;
    last_next_s     = last_r;
    if (state_next_s != state_r) begin
      hold_cnt_next_s = 8'd0;
      if (state_next_s == OWN0) begin
        last_next_s = 1'b0;
      end else if (state_next_s == OWN1) begin
        last_next_s = 1'b1;
      end else begin
        last_next_s = last_r;
      end
    end else begin
      hold_cnt_next_s = hold_sat_s;
    end
  end

  // Arbitration state; last winner resets to 1 so port 0 takes the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      hold_cnt_r <= 8'd0;
      last_r     <= 1'b1;
    end else begin
      state_r    <= state_next_s;
      hold_cnt_r <= hold_cnt_next_s;
      last_r     <= last_next_s;
    end
  end

  // Read-return strobes line up with the memory's 1-cycle latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
    end else begin
      rvalid0_r <= gnt0_s & ~bus.we0;
      rvalid1_r <= gnt1_s & ~bus.we1;
    end
  end

  assign bus.gnt0      = gnt0_s;
  assign bus.gnt1      = gnt1_s;
  assign bus.mem_en    = mem_en_s;
  assign bus.mem_we    = mem_we_s;
  assign bus.mem_addr  = mem_addr_s;
  assign bus.mem_wdata = mem_wdata_s;
  assign bus.rvalid0   = rvalid0_r;
  assign bus.rvalid1   = rvalid1_r;
  assign bus.rdata0    = bus.mem_rdata;
  assign bus.rdata1    = bus.mem_rdata;

  mem_arbiter_checker u_checker (
    .clk     (clk),
    .reset   (reset),
    .gnt0    (gnt0_s),
    .gnt1    (gnt1_s),
    .we0     (bus.we0),
    .we1     (bus.we1),
    .mem_en  (mem_en_s),
    .rvalid0 (rvalid0_r),
    .rvalid1 (rvalid1_r),
    .last    (last_r)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scenario tasks plus a read-return scoreboard.
// Expectations follow ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_mem_arbiter;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [DATA_W-1:0] mem     [0:255];
  logic [DATA_W-1:0] ref_mem [0:255];
  logic              mem_ready = 1'b0;
  logic [DATA_W-1:0] exp_q0 [$];
  logic [DATA_W-1:0] exp_q1 [$];

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] init_word(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // Single-port memory with 1-cycle read latency.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (bus.mem_en === 1'b1) begin
      if (bus.mem_we === 1'b1) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      else bus.mem_rdata <= mem[bus.mem_addr[7:0]];
    end
  end

  // Scoreboard: every rvalid pops the expected read word; grants must never overlap.
  always @(negedge clk) begin : monitor
    logic [DATA_W-1:0] e;
    if (reset === 1'b0) begin
      n_checks++;
      if ((bus.gnt0 & bus.gnt1) !== 1'b0) begin
        n_fail++;
        $display("FAIL gnt_exclusive: gnt0=%b gnt1=%b, required not both high", bus.gnt0, bus.gnt1);
      end
      if (bus.rvalid0 === 1'b1) begin
        n_checks++;
        if (exp_q0.size() == 0) begin
          n_fail++;
          $display("FAIL rvalid0_unexpected: rvalid0=1, required 0 (no read pending)");
        end else begin
          e = exp_q0.pop_front();
          if (bus.rdata0 !== e) begin
            n_fail++;
            $display("FAIL rdata0: got %h, expected %h", bus.rdata0, e);
          end
        end
      end
      if (bus.rvalid1 === 1'b1) begin
        n_checks++;
        if (exp_q1.size() == 0) begin
          n_fail++;
          $display("FAIL rvalid1_unexpected: rvalid1=1, required 0 (no read pending)");
        end else begin
          e = exp_q1.pop_front();
          if (bus.rdata1 !== e) begin
            n_fail++;
            $display("FAIL rdata1: got %h, expected %h", bus.rdata1, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic req, input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req0 = req; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
  endtask

  task automatic drive1(input logic req, input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req1 = req; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive0(1'b0, 1'b0, 32'h0, 32'h0);
    drive1(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus.gnt0, bus.gnt1, bus.mem_en, bus.rvalid0, bus.rvalid1} !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_held: gnt/mem_en/rvalid=%b, expected 00000",
               {bus.gnt0, bus.gnt1, bus.mem_en, bus.rvalid0, bus.rvalid1});
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.gnt0, bus.gnt1, bus.mem_en, bus.mem_we, bus.rvalid0, bus.rvalid1} !== 6'b000000) begin
      n_fail++;
      $display("FAIL reset_release: gnt/mem_en/mem_we/rvalid=%b, expected 000000",
               {bus.gnt0, bus.gnt1, bus.mem_en, bus.mem_we, bus.rvalid0, bus.rvalid1});
    end
  endtask

  task automatic test_single_read();
    tick(); drive0(1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({bus.gnt0, bus.mem_en} !== 2'b00) begin
      n_fail++; $display("FAIL single_read_idle: gnt0/mem_en=%b, expected 00", {bus.gnt0, bus.mem_en});
    end
    tick(); @(negedge clk);
    n_checks++;
    if ({bus.gnt0, bus.mem_en, bus.mem_we} !== 3'b110 || bus.mem_addr !== 32'h10) begin
      n_fail++; $display("FAIL single_read_grant: gnt0/en/we=%b addr=%h, expected 110 addr=00000010",
                         {bus.gnt0, bus.mem_en, bus.mem_we}, bus.mem_addr);
    end
    exp_q0.push_back(ref_mem[8'h10]);
    tick(); drive0(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({bus.rvalid0, bus.rvalid1} !== 2'b10) begin
      n_fail++; $display("FAIL single_read_rvalid: rvalid0/1=%b, expected 10", {bus.rvalid0, bus.rvalid1});
    end
    tick(); @(negedge clk);
    n_checks++;
    if (exp_q0.size() != 0 || bus.rvalid0 !== 1'b0) begin
      n_fail++; $display("FAIL single_read_drain: pending=%0d rvalid0=%b, expected 0 and 0", exp_q0.size(), bus.rvalid0);
    end
  endtask

  task automatic test_tie();
    logic eg0;
    logic eg1;
    int   own;
    do_reset();
    drive0(1'b1, 1'b0, 32'h30, 32'h0);
    drive1(1'b1, 1'b0, 32'h40, 32'h0);
    for (int c = 0; c < 14; c++) begin
      if (c > 0) tick();
      @(negedge clk);
`ifdef ARB_ROUND_ROBIN_EN
      own = ((c - 1) / MAX_HOLD) % 2;
`else
      own = 0;
`endif
      eg0 = (c > 0) && (own == 0);
      eg1 = (c > 0) && (own == 1);
      n_checks++;
      if ({bus.gnt0, bus.gnt1} !== {eg0, eg1}) begin
        n_fail++; $display("FAIL tie_cycle%0d: gnt0/gnt1=%b, expected %b", c, {bus.gnt0, bus.gnt1}, {eg0, eg1});
      end
      if (eg0) exp_q0.push_back(ref_mem[8'h30]);
      if (eg1) exp_q1.push_back(ref_mem[8'h40]);
    end
    tick();
    drive0(1'b0, 1'b0, 32'h0, 32'h0);
    drive1(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    tick(); @(negedge clk);
    n_checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_fail++; $display("FAIL tie_drain: pending=%0d/%0d, expected 0/0", exp_q0.size(), exp_q1.size());
    end
  endtask

  task automatic test_write_read();
    tick(); drive1(1'b1, 1'b1, 32'h20, 32'hDEADBEEF);
    @(negedge clk);
    n_checks++;
    if (bus.gnt1 !== 1'b0) begin
      n_fail++; $display("FAIL wr_idle: gnt1=%b, expected 0", bus.gnt1);
    end
    tick(); @(negedge clk);
    n_checks++;
    if ({bus.gnt1, bus.mem_en, bus.mem_we} !== 3'b111 || bus.mem_addr !== 32'h20 || bus.mem_wdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL wr_write: gnt1/en/we=%b addr=%h wdata=%h, expected 111 00000020 deadbeef",
                         {bus.gnt1, bus.mem_en, bus.mem_we}, bus.mem_addr, bus.mem_wdata);
    end
    ref_mem[8'h20] = 32'hDEADBEEF;
    tick(); drive1(1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({bus.gnt1, bus.mem_we, bus.rvalid1} !== 3'b100) begin
      n_fail++; $display("FAIL wr_read_issue: gnt1/we/rvalid1=%b, expected 100", {bus.gnt1, bus.mem_we, bus.rvalid1});
    end
    exp_q1.push_back(ref_mem[8'h20]);
    tick(); drive1(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    n_checks++;
    if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL wr_read_return: rvalid1=%b rdata1=%h, expected 1 deadbeef", bus.rvalid1, bus.rdata1);
    end
    tick(); @(negedge clk);
    n_checks++;
    if (exp_q1.size() != 0) begin
      n_fail++; $display("FAIL wr_drain: pending=%0d, expected 0", exp_q1.size());
    end
  endtask

  task automatic test_owner_drop();
    tick(); drive0(1'b1, 1'b0, 32'h50, 32'h0);
    @(negedge clk);
    tick(); drive1(1'b1, 1'b0, 32'h60, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      n_fail++; $display("FAIL drop_own0: gnt0/gnt1=%b, expected 10", {bus.gnt0, bus.gnt1});
    end
    exp_q0.push_back(ref_mem[8'h50]);
    tick(); drive0(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({bus.gnt0, bus.gnt1, bus.mem_en} !== 3'b000) begin
      n_fail++; $display("FAIL drop_release: gnt0/gnt1/en=%b, expected 000", {bus.gnt0, bus.gnt1, bus.mem_en});
    end
    tick(); @(negedge clk);
    n_checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
      n_fail++; $display("FAIL drop_handover: gnt0/gnt1=%b, expected 01", {bus.gnt0, bus.gnt1});
    end
    exp_q1.push_back(ref_mem[8'h60]);
    tick(); drive1(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    tick(); @(negedge clk);
    n_checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_fail++; $display("FAIL drop_drain: pending=%0d/%0d, expected 0/0", exp_q0.size(), exp_q1.size());
    end
  endtask

  task automatic test_hold_preempt();
    tick(); drive1(1'b1, 1'b0, 32'h70, 32'h0);
    @(negedge clk);
    for (int i = 0; i < MAX_HOLD; i++) begin
      tick();
      if (i == 1) drive0(1'b1, 1'b0, 32'h74, 32'h0);
      @(negedge clk);
      n_checks++;
      if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
        n_fail++; $display("FAIL hold_own1_%0d: gnt0/gnt1=%b, expected 01", i, {bus.gnt0, bus.gnt1});
      end
      exp_q1.push_back(ref_mem[8'h70]);
    end
    tick(); drive1(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      n_fail++; $display("FAIL hold_preempt1: gnt0/gnt1=%b, expected 10", {bus.gnt0, bus.gnt1});
    end
    exp_q0.push_back(ref_mem[8'h74]);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 5) drive1(1'b1, 1'b0, 32'h70, 32'h0);
      @(negedge clk);
      n_checks++;
      if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
        n_fail++; $display("FAIL hold_own0_%0d: gnt0/gnt1=%b, expected 10", i, {bus.gnt0, bus.gnt1});
      end
      exp_q0.push_back(ref_mem[8'h74]);
    end
    tick(); @(negedge clk);
    n_checks++;
`ifdef ARB_ROUND_ROBIN_EN
    if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
      n_fail++; $display("FAIL hold_saturated_switch: gnt0/gnt1=%b, expected 01", {bus.gnt0, bus.gnt1});
    end
    exp_q1.push_back(ref_mem[8'h70]);
`else
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      n_fail++; $display("FAIL hold_no_preempt0: gnt0/gnt1=%b, expected 10", {bus.gnt0, bus.gnt1});
    end
    exp_q0.push_back(ref_mem[8'h74]);
`endif
    tick();
    drive0(1'b0, 1'b0, 32'h0, 32'h0);
    drive1(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    tick(); @(negedge clk);
    n_checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_fail++; $display("FAIL hold_drain: pending=%0d/%0d, expected 0/0", exp_q0.size(), exp_q1.size());
    end
  endtask

  task automatic test_reset_mid();
    tick(); drive0(1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    tick(); @(negedge clk);
    n_checks++;
    if (bus.gnt0 !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_grant: gnt0=%b, expected 1", bus.gnt0);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.gnt0, bus.mem_en} !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid_async: gnt0/mem_en=%b, expected 00", {bus.gnt0, bus.mem_en});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive0(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    n_checks++;
    if (bus.rvalid0 !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_rvalid: rvalid0=%b, expected 0", bus.rvalid0);
    end
    tick();
    drive0(1'b1, 1'b0, 32'h10, 32'h0);
    drive1(1'b1, 1'b0, 32'h40, 32'h0);
    @(negedge clk);
    n_checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid_idle: gnt0/gnt1=%b, expected 00", {bus.gnt0, bus.gnt1});
    end
    tick(); @(negedge clk);
    n_checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      n_fail++; $display("FAIL rst_mid_first_tie: gnt0/gnt1=%b, expected 10", {bus.gnt0, bus.gnt1});
    end
    exp_q0.push_back(ref_mem[8'h10]);
    tick();
    drive0(1'b0, 1'b0, 32'h0, 32'h0);
    drive1(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    tick(); @(negedge clk);
    n_checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      n_fail++; $display("FAIL rst_mid_drain: pending=%0d/%0d, expected 0/0", exp_q0.size(), exp_q1.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    test_reset();
    test_single_read();
    test_tie();
    test_write_read();
    test_owner_drop();
    test_hold_preempt();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter MAX_HOLD, default 4, the number of accesses an owner may issue before yielding to a waiting requester (range 1..255).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports req0/req1  input  1  access request from port 0 (CPU data side) and port 1 (DMA/loader).
REQ-007 SHALL have ports we0/we1  input  1  write enable for each port.
REQ-008 SHALL have ports addr0/addr1  input  ADDR_W  and wdata0/wdata1  input  DATA_W  access address and write data for each port.
REQ-009 SHALL have ports gnt0/gnt1  output  1  access accepted this cycle.
REQ-010 SHALL have ports rvalid0/rvalid1  output  1  and rdata0/rdata1  output  DATA_W  read return for each port.
REQ-011 SHALL have ports mem_en, mem_we  output  1; mem_addr  output  ADDR_W; mem_wdata  output  DATA_W; mem_rdata  input  DATA_W  single-port memory with 1-cycle read latency.

Function
REQ-012 SHALL implement FSM states IDLE, OWN0 and OWN1, with state held in flops.
REQ-013 In IDLE, SHALL assert no gnt and no mem_en; if any req is high, next state SHALL be OWN of the arbitration winner, giving a 1-cycle grant latency from IDLE.
REQ-014 In OWNn, gnt_n SHALL equal req_n combinationally, and gnt of the other port SHALL be 0.
REQ-015 An access SHALL occur in every cycle with req_n && gnt_n: mem_en=1 and mem_we/mem_addr/mem_wdata equal we_n/addr_n/wdata_n in that same cycle; otherwise mem_en=0 and mem_we=0.
REQ-016 SHALL count accesses per ownership in an 8-bit hold counter, cleared on every state change.
REQ-017 SHALL leave OWNn to IDLE in the cycle after req_n is sampled low, provided the other req is low.
REQ-018 SHALL switch OWNn directly to OWNm (m≠n) when the other req is high and either req_n is low or the hold counter reaches MAX_HOLD after the current access.
REQ-019 If the hold counter reaches MAX_HOLD while the other req is low, SHALL stay in OWNn and saturate the counter at MAX_HOLD.
REQ-020 SHALL assert rvalid_n for exactly one cycle, in the cycle after a read access (we=0) granted to port n.
REQ-021 SHALL drive rdata0 and rdata1 from mem_rdata; rdata is meaningful only while the matching rvalid is high.
REQ-022 Writes SHALL produce no rvalid.
REQ-023 SHALL track the last winner in a flop updated on every entry into OWNn.

Reset
REQ-024 On reset, SHALL set state=IDLE, hold counter=0, rvalid0=rvalid1=0 and last winner=1, so that port 0 wins the first tie.
REQ-025 A reset asserted mid-ownership SHALL drop any pending rvalid, and mem_en/gnt SHALL be 0 immediately (asynchronously).

Configuration
REQ-026 When ARB_ROUND_ROBIN_EN is defined, a tie in IDLE SHALL go to the port that is not the last winner, and MAX_HOLD preemption (REQ-018) SHALL be active.
REQ-027 When ARB_ROUND_ROBIN_EN is undefined, a tie in IDLE SHALL always go to port 0, port 1 SHALL never preempt port 0 by MAX_HOLD, and port 0 SHALL preempt port 1 after MAX_HOLD.

Verification
REQ-028 Single read: req0=1, we0=0, addr0=0x10 from IDLE -> gnt0=1 in cycle 2, mem_addr=0x10, rvalid0=1 in cycle 3 with rdata0=mem[0x10].
REQ-029 Tie after reset (round robin on): req0=req1=1 held -> OWN0 for MAX_HOLD=4 accesses, then OWN1 for 4, then OWN0 again; no cycle has gnt0&&gnt1.
REQ-030 Tie with macro off: same stimulus -> port 0 owns continuously and gnt1 stays 0.
REQ-031 Write then read: port 1 writes 0xDEADBEEF to 0x20, then reads 0x20 -> rvalid1=1 with rdata1=0xDEADBEEF; no rvalid on the write.
REQ-032 Owner drops req: req0 drops while req1=1 -> next cycle OWN1 with gnt1=1 and no IDLE bubble.
REQ-033 Reset mid-op: assert reset on the cycle of a port-0 read -> rvalid0 stays 0 the following cycle, state is IDLE, and the first post-reset tie goes to port 0.
